// File: rtl/riscv_core_rob_complete_arb.sv
// ROB completion arbiter: four per-requester completion FIFOs
// drained two per cycle into the ROB mark ports, round-robin.
module riscv_core_rob_complete_arb #(
  parameter int QDEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic [3:0]  req_val,
  input  logic [19:0] req_slot,
  output logic [3:0]  req_rdy,
  output logic        cmp_val_A,
  output logic [4:0]  cmp_slot_A,
  output logic        cmp_val_B,
  output logic [4:0]  cmp_slot_B,
  output logic        busy
);

  localparam int PW = (QDEPTH == 4) ? 2 : 1;
  localparam int CW = 3;
  localparam logic [CW-1:0] QD = CW'(QDEPTH);

  logic [4:0]    mem    [4][QDEPTH];
  logic [PW-1:0] rd_ptr [4];
  logic [PW-1:0] wr_ptr [4];
  logic [CW-1:0] count  [4];
  logic [1:0]    rr_ptr;

  logic [3:0] nonempty;
  logic [3:0] enq;
  logic [3:0] deq;
  logic       have_a;
  logic       have_b;
  logic [1:0] a_idx;
  logic [1:0] b_idx;
  logic [1:0] idx;
  logic [1:0] last;
  logic [4:0] head [4];

  // Per-FIFO status, heads and accept decisions
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      nonempty[i] = (count[i] != '0);
      req_rdy[i]  = (count[i] < QD);
      enq[i]      = req_val[i] && req_rdy[i] && !flush;
      head[i]     = mem[i][rd_ptr[i]];
    end
  end

  // Round-robin scan: first candidate to A, second to B
  always_comb begin
    have_a = 1'b0;
    have_b = 1'b0;
    a_idx  = 2'd0;
    b_idx  = 2'd0;
    idx    = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = rr_ptr + 2'(k);
      if (nonempty[idx]) begin
        if (!have_a) begin
          have_a = 1'b1;
          a_idx  = idx;
        end else if (!have_b) begin
          have_b = 1'b1;
          b_idx  = idx;
        end
      end
    end
    last = have_b ? b_idx : a_idx;
    for (int i = 0; i < 4; i++) begin
      deq[i] = (have_a && a_idx == 2'(i)) ||
               (have_b && b_idx == 2'(i));
    end
  end

  // Completion ports and busy flag
  always_comb begin
    cmp_val_A  = have_a;
    cmp_slot_A = have_a ? head[a_idx] : 5'd0;
    cmp_val_B  = have_b;
    cmp_slot_B = have_b ? head[b_idx] : 5'd0;
    busy       = |nonempty;
  end

  // FIFO storage writes; contents need no reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!reset && enq[i]) begin
        mem[i][wr_ptr[i]] <= req_slot[5*i +: 5];
      end
    end
  end

  // Pointers, occupancy and round-robin state
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < 4; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      if (have_a) begin
        rr_ptr <= last + 2'd1;
      end
      for (int i = 0; i < 4; i++) begin
        if (enq[i]) begin
          wr_ptr[i] <= wr_ptr[i] + PW'(1);
        end
        if (deq[i]) begin
          rd_ptr[i] <= rd_ptr[i] + PW'(1);
        end
        unique case ({enq[i], deq[i]})
          2'b10:   count[i] <= count[i] + 3'd1;
          2'b01:   count[i] <= count[i] - 3'd1;
          default: count[i] <= count[i];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_riscv_core_rob_complete_arb.sv
// Directed bench for the ROB completion arbiter:
// cycle-trace table plus fairness and full-queue sequences.
module tb_riscv_core_rob_complete_arb;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic [3:0]  req_val = 4'd0;
  logic [19:0] req_slot = 20'd0;
  logic [3:0]  req_rdy;
  logic        cmp_val_A;
  logic [4:0]  cmp_slot_A;
  logic        cmp_val_B;
  logic [4:0]  cmp_slot_B;
  logic        busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  riscv_core_rob_complete_arb #(.QDEPTH(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .req_val    (req_val),
    .req_slot   (req_slot),
    .req_rdy    (req_rdy),
    .cmp_val_A  (cmp_val_A),
    .cmp_slot_A (cmp_slot_A),
    .cmp_val_B  (cmp_val_B),
    .cmp_slot_B (cmp_slot_B),
    .busy       (busy)
  );

  typedef struct {
    logic        rst;
    logic        fl;
    logic [3:0]  val;
    logic [19:0] slot;
    logic        chk;
    logic [16:0] exp;
  } vec_t;

  vec_t vec [24];

  function automatic logic [19:0] sl(int s3, int s2, int s1, int s0);
    return {5'(s3), 5'(s2), 5'(s1), 5'(s0)};
  endfunction

  function automatic logic [16:0] ex(logic [3:0] rdy, logic va,
                                     int sa, logic vb, int sb,
                                     logic bsy);
    return {rdy, va, 5'(sa), vb, 5'(sb), bsy};
  endfunction

  function automatic vec_t mk(logic rst, logic fl, logic [3:0] val,
                              logic [19:0] slot, logic chk,
                              logic [16:0] e);
    vec_t v;
    v.rst  = rst;
    v.fl   = fl;
    v.val  = val;
    v.slot = slot;
    v.chk  = chk;
    v.exp  = e;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [16:0] outs();
    return {req_rdy, cmp_val_A, cmp_slot_A, cmp_val_B, cmp_slot_B, busy};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    flush = 1'b0;
    req_val = 4'd0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [16:0] idle;
  int          got [$];
  int          idx;
  int          w;
  logic        low_seen;
  logic        pair_ok;

  initial begin
    idle = ex(4'hF, 0, 0, 0, 0, 0);
    vec[0]  = mk(1, 0, 4'b0000, sl(0, 0, 0, 0), 0, idle);
    vec[1]  = mk(0, 0, 4'b0000, sl(0, 0, 0, 0), 1, idle);
    vec[2]  = mk(0, 0, 4'b0100, sl(0, 7, 0, 0), 1, idle);
    vec[3]  = mk(0, 0, 4'b0000, sl(0, 0, 0, 0), 1,
                 ex(4'hF, 1, 7, 0, 0, 1));
    vec[4]  = mk(0, 0, 4'b1000, sl(9, 0, 0, 0), 1, idle);
    vec[5]  = mk(0, 0, 4'b0000, sl(0, 0, 0, 0), 1,
                 ex(4'hF, 1, 9, 0, 0, 1));
    vec[6]  = mk(0, 0, 4'b1111, sl(4, 3, 2, 1), 1, idle);
    vec[7]  = mk(0, 0, 4'b0000, sl(0, 0, 0, 0), 1,
                 ex(4'hF, 1, 1, 1, 2, 1));
    vec[8]  = mk(0, 0, 4'b0000, sl(0, 0, 0, 0), 1,
                 ex(4'hF, 1, 3, 1, 4, 1));
    vec[9]  = mk(0, 0, 4'b1001, sl(13, 0, 0, 10), 1, idle);
    vec[10] = mk(0, 0, 4'b0000, sl(0, 0, 0, 0), 1,
                 ex(4'hF, 1, 10, 1, 13, 1));
    vec[11] = mk(0, 0, 4'b0000, sl(0, 0, 0, 0), 1, idle);
    vec[12] = mk(0, 0, 4'b0111, sl(0, 3, 2, 1), 1, idle);
    vec[13] = mk(0, 1, 4'b0001, sl(0, 0, 0, 9), 1,
                 ex(4'hF, 1, 1, 1, 2, 1));
    vec[14] = mk(0, 0, 4'b0000, sl(0, 0, 0, 0), 1, idle);
    vec[15] = mk(0, 0, 4'b0000, sl(0, 0, 0, 0), 1, idle);
    vec[16] = mk(0, 0, 4'b1111, sl(14, 13, 12, 11), 1, idle);
    vec[17] = mk(1, 0, 4'b0001, sl(0, 0, 0, 15), 1,
                 ex(4'hF, 1, 11, 1, 12, 1));
    for (int r = 18; r < 24; r++) begin
      vec[r] = mk(0, 0, 4'b0000, sl(0, 0, 0, 0), 1, idle);
    end

    for (int r = 0; r < 24; r++) begin
      @(negedge clk);
      reset    = vec[r].rst;
      flush    = vec[r].fl;
      req_val  = vec[r].val;
      req_slot = vec[r].slot;
      if (vec[r].chk) begin
        check($sformatf("row%0d", r), 32'(outs()), 32'(vec[r].exp));
      end
    end

    // Fairness: requesters 0 and 3 held valid for 21 cycles
    do_reset();
    for (int c = 0; c < 21; c++) begin
      @(negedge clk);
      req_val  = 4'b1001;
      req_slot = sl(13, 0, 0, 10);
      if (c > 0) begin
        pair_ok = cmp_val_A && cmp_val_B &&
                  ((cmp_slot_A == 5'd10 && cmp_slot_B == 5'd13) ||
                   (cmp_slot_A == 5'd13 && cmp_slot_B == 5'd10));
        check($sformatf("fair%0d", c), 32'(pair_ok), 32'd1);
      end
    end
    @(negedge clk);
    req_val = 4'd0;
    w = 0;
    while (busy && w < 10) begin
      @(negedge clk);
      w++;
    end
    check("fair_drain", 32'(busy), 32'd0);

    // Full queue: requester 1 sends 5..8 against 0,2,3 contention
    do_reset();
    idx = 0;
    low_seen = 1'b0;
    got.delete();
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (idx >= 4 && got.size() >= 4) break;
      check("b_needs_a", 32'(cmp_val_B && !cmp_val_A), 32'd0);
      if (cmp_val_A && cmp_slot_A >= 5'd5 && cmp_slot_A <= 5'd8)
        got.push_back(int'(cmp_slot_A));
      if (cmp_val_B && cmp_slot_B >= 5'd5 && cmp_slot_B <= 5'd8)
        got.push_back(int'(cmp_slot_B));
      if (idx < 4 && !req_rdy[1]) low_seen = 1'b1;
      req_val  = (idx < 4) ? 4'b1111 : 4'b0000;
      req_slot = sl(23, 22, 5 + idx, 20);
      if (idx < 4 && req_rdy[1]) idx++;
    end
    req_val = 4'd0;
    check("full_rdy_low", 32'(low_seen), 32'd1);
    check("full_count", 32'(got.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < got.size())
        check($sformatf("full_order%0d", k), 32'(got[k]), 32'(5 + k));
    end
    w = 0;
    while (busy && w < 30) begin
      @(negedge clk);
      w++;
    end
    check("full_drain", 32'(busy), 32'd0);
    check("full_idle", 32'(outs()), 32'(idle));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
